data_mem_arbiter: RTL and testbench
===================================

// Module: data_mem_arbiter
// PURPOSE
//  Shares the byte-wide single-port data memory between two word requesters:
//  core load/store (id 0) and loader/debug port (id 1).
//  Round-robin arbitration, then each 32-bit access is serialised into WIDTH/8
//  little-endian byte beats. Sits between the requesters and the dataMemory
//  array, which has a combinational read.
// PARAMETERS
//  WIDTH       32  word width; must be a multiple of 8; BEATS = WIDTH/8
//  ADDR_WIDTH  8   byte address width (memory depth = 2**ADDR_WIDTH)
// PORTS
//  clock       in   1                 single clock, rising edge
//  reset       in   1                 asynchronous, active-high
//  req_valid   in   [2]               request present, per requester
//  req_write   in   [2]               1 = store word, 0 = load word
//  req_addr    in   [2][ADDR_WIDTH]   byte address of byte 0; need not be aligned
//  req_wdata   in   [2][WIDTH]        store data
//  req_ready   out  [2]               request accepted this cycle (one-hot or 0)
//  resp_valid  out  [2]               1-cycle pulse: access complete
//  resp_rdata  out  WIDTH             load data; valid with resp_valid, held until next load completes
//  busy        out  1                 state != IDLE
//  mem_addr    out  ADDR_WIDTH        byte address to memory
//  mem_we      out  1                 byte write enable
//  mem_wdata   out  8                 byte write data
//  mem_rdata   in   8                 byte read data, same cycle as mem_addr
// BEHAVIOUR
//  - Reset (async): state=IDLE, beat=0, last_grant=1 (id 0 wins first tie),
//    resp_rdata=0. While reset is high, every output is 0.
//  - FSM IDLE -> XFER -> RESP -> IDLE.
//  - IDLE: grant = the only valid requester; if both are valid, grant the one
//    != last_grant. req_ready[grant] = 1 combinationally.
//    On that edge: latch id, write, addr, wdata; set last_grant=id; beat=0; go XFER.
//    If neither is valid, stay in IDLE with all outputs 0.
//  - XFER, beat b = 0..BEATS-1, one cycle each:
//    mem_addr = latched addr + b, modulo 2**ADDR_WIDTH (wraps).
//    Write: mem_we=1, mem_wdata = wdata[8b+7:8b].
//    Read: mem_we=0; rdata byte b <= mem_rdata at the edge.
//    After beat BEATS-1, go RESP.
//  - RESP: resp_valid[id]=1 for one cycle. For loads, resp_rdata updates at
//    entry to RESP. Next state IDLE.
//  - Latency: accept at T, beats T+1..T+BEATS, resp at T+BEATS+1.
//    At most one accept per BEATS+2 cycles.
//  - mem_we, mem_addr, mem_wdata decode from state only; they are 0 outside XFER.
//  - Requesters hold req_* until req_ready. Changes to a requester's inputs
//    after acceptance are ignored. A non-granted valid request waits.
//    Round-robin bounds its wait to one access.
//  - Reset during XFER: abort at once. mem_we drops asynchronously. Bytes
//    already written stay written. No resp_valid is issued.
//  - A request arriving in RESP is not seen until IDLE; there is no bypass.
// STRUCTURE
//  - Package data_mem_arb_pkg: state_e {IDLE, XFER, RESP}, REQ_CORE=0,
//    REQ_LOADER=1, function beats(WIDTH).
//  - Sub-module rr_arbiter2: valid[2] + last_grant -> grant_valid, grant_id.
//    Purely combinational.
//  - Top holds the FSM, beat counter ($clog2(BEATS) bits), and the request
//    and rdata registers.
// TESTING
//  1. Reset held, requests driven -> req_ready, resp_valid, mem_we, busy all 0.
//     After release, IDLE.
//  2. id0 writes addr 0x10, data 0xDEADBEEF. Accept at T. T+1..T+4:
//     mem_we=1, addr 10/11/12/13, bytes EF/BE/AD/DE. resp_valid[0] at T+5.
//  3. id1 reads 0x10 after test 2 -> resp_valid[1] at T+5,
//     resp_rdata=0xDEADBEEF, held after the pulse.
//  4. Both valid continuously from reset -> grants alternate 0,1,0,1.
//     Accepts every 6 cycles. No grant while busy.
//  5. Write addr 0xFE, data 0x11223344 -> mem writes FE=44, FF=33, 00=22, 01=11.
//     Read 0xFE returns 0x11223344.
//  6. Assert reset in beat 2 of a write to 0x20 -> mem_we=0 at once, no
//     resp_valid. Only 0x20 and 0x21 are written. The next request completes
//     normally.

Source files
------------

// File: rtl/data_mem_arbiter_pkg.sv
// rtl/data_mem_arbiter_pkg.sv - shared types and helpers for the data memory arbiter
package data_mem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      RESP = 2'd2
   } state_e;

   localparam int REQ_CORE   = 0;
   localparam int REQ_LOADER = 1;

   function automatic int beats(input int width);
      return width / 8;
   endfunction

endpackage

// File: rtl/data_mem_arbiter_if.sv
// rtl/data_mem_arbiter_if.sv - requester, response and byte-memory signals of the arbiter
interface data_mem_arbiter_if #(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 8
);
   logic [1:0]                 req_valid;
   logic [1:0]                 req_write;
   logic [1:0][ADDR_WIDTH-1:0] req_addr;
   logic [1:0][WIDTH-1:0]      req_wdata;
   logic [1:0]                 req_ready;
   logic [1:0]                 resp_valid;
   logic [WIDTH-1:0]           resp_rdata;
   logic                       busy;
   logic [ADDR_WIDTH-1:0]      mem_addr;
   logic                       mem_we;
   logic [7:0]                 mem_wdata;
   logic [7:0]                 mem_rdata;

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, mem_rdata,
      output req_ready, resp_valid, resp_rdata, busy, mem_addr, mem_we, mem_wdata
   );

   modport master (
      output req_valid, req_write, req_addr, req_wdata, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, busy, mem_addr, mem_we, mem_wdata
   );
endinterface

// File: rtl/data_mem_arbiter_rr.sv
// rtl/data_mem_arbiter_rr.sv - two-way round-robin grant, combinational
module rr_arbiter2
   import data_mem_arb_pkg::*;
(
   input  logic [1:0] valid_i,
   input  logic       last_grant_i,
   output logic       grant_valid_o,
   output logic       grant_id_o
);

   // On a tie the requester that did not win last time is favoured.
   assign grant_valid_o = |valid_i;
   assign grant_id_o    = (&valid_i) ? ~last_grant_i : valid_i[REQ_LOADER];

endmodule

// File: rtl/data_mem_arbiter.sv
// rtl/data_mem_arbiter.sv - round-robin word requesters onto a byte-wide memory
module data_mem_arbiter
   import data_mem_arb_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter int ADDR_WIDTH = 8
) (
   input logic               clock,
   input logic               reset,
   data_mem_arbiter_if.slave bus
);

   localparam int BEATS  = beats(WIDTH);
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

   state_e                state_q;
   logic [BEAT_W-1:0]     beat_q;
   logic                  last_grant_q;
   logic                  id_q;
   logic                  write_q;
   logic [ADDR_WIDTH-1:0] addr_q;
   logic [WIDTH-1:0]      wdata_q;
   logic [WIDTH-1:0]      rbuf_q;
   logic [WIDTH-1:0]      rbuf_d;
   logic [WIDTH-1:0]      rdata_q;

   logic grant_valid;
   logic grant_id;
   logic accept;
   logic in_xfer;
   logic last_beat;

   rr_arbiter2 u_rr (
      .valid_i       (bus.req_valid),
      .last_grant_i  (last_grant_q),
      .grant_valid_o (grant_valid),
      .grant_id_o    (grant_id)
   );

   assign accept    = (state_q == IDLE) && grant_valid && !reset;
   assign in_xfer   = (state_q == XFER);
   assign last_beat = (beat_q == BEAT_W'(BEATS - 1));

   // Read data is assembled with the current byte folded in so RESP sees the full word.
   always_comb begin
      rbuf_d = rbuf_q;
      rbuf_d[8*beat_q +: 8] = bus.mem_rdata;
   end

   assign bus.req_ready  = accept ? (2'b01 << grant_id) : 2'b00;
   assign bus.resp_valid = (state_q == RESP) ? (2'b01 << id_q) : 2'b00;
   assign bus.resp_rdata = rdata_q;
   assign bus.busy       = (state_q != IDLE);
   assign bus.mem_we     = in_xfer && write_q;
   assign bus.mem_addr   = in_xfer ? addr_q + ADDR_WIDTH'(beat_q) : '0;
   assign bus.mem_wdata  = (in_xfer && write_q) ? wdata_q[8*beat_q +: 8] : 8'h00;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         beat_q       <= '0;
         last_grant_q <= 1'b1;
         id_q         <= 1'b0;
         write_q      <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
         rbuf_q       <= '0;
         rdata_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (grant_valid) begin
                  id_q         <= grant_id;
                  write_q      <= bus.req_write[grant_id];
                  addr_q       <= bus.req_addr[grant_id];
                  wdata_q      <= bus.req_wdata[grant_id];
                  last_grant_q <= grant_id;
                  beat_q       <= '0;
                  state_q      <= XFER;
               end
            end
            XFER: begin
               if (!write_q) begin
                  rbuf_q <= rbuf_d;
               end
               if (last_beat) begin
                  beat_q  <= '0;
                  state_q <= RESP;
                  if (!write_q) begin
                     rdata_q <= rbuf_d;
                  end
               end else begin
                  beat_q <= beat_q + 1'b1;
               end
            end
            RESP: begin
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// tb/tb_data_mem_arbiter.sv - scoreboard bench for data_mem_arbiter
module tb_data_mem_arbiter;
   import data_mem_arb_pkg::*;

   localparam int WIDTH = 32;
   localparam int AW    = 8;
   localparam int BEATS = WIDTH / 8;
   localparam int WAIT_BOUND = 2 * (BEATS + 2);

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   data_mem_arbiter_if #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dif ();

   data_mem_arbiter #(.WIDTH(WIDTH), .ADDR_WIDTH(AW)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (dif)
   );

   logic [1:0]       rv = 2'b00;
   logic [1:0]       rw = 2'b00;
   logic [AW-1:0]    ra [2];
   logic [WIDTH-1:0] rd [2];

   assign dif.req_valid = rv;
   assign dif.req_write = rw;
   assign dif.req_addr  = {ra[1], ra[0]};
   assign dif.req_wdata = {rd[1], rd[0]};

   bit [7:0] mem [256];
   assign dif.mem_rdata = mem[dif.mem_addr];
   always @(posedge clock) if (dif.mem_we) mem[dif.mem_addr] <= dif.mem_wdata;

   typedef struct {
      int          id;
      bit          wr;
      logic [31:0] rdata;
      int          due;
   } exp_t;

   typedef struct {
      logic [7:0] addr;
      logic [7:0] data;
      logic [7:0] old;
   } wb_t;

   exp_t        expq [$];
   wb_t         wq [$];
   int          gseq [$];
   bit   [7:0]  ref_mem [256];
   int          acc_cnt [2];
   int          tb_last = 1;
   int          last_acc = -1;
   bit          strict_gap = 1'b0;
   logic [31:0] held = '0;
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // An aborted write leaves only the beats that reached memory; undo the rest.
   always @(posedge reset) begin
      while (wq.size() != 0) begin
         wb_t w;
         w = wq.pop_back();
         ref_mem[w.addr] = w.old;
      end
      expq.delete();
      tb_last  = 1;
      last_acc = -1;
      held     = '0;
   end

   always @(negedge clock) begin
      exp_t       e;
      wb_t        w;
      int         id;
      logic [7:0] a;
      logic [1:0] rdy;
      logic [1:0] oh;
      if (reset) begin
         chk("reset_outputs", {dif.req_ready, dif.resp_valid, dif.mem_we, dif.busy,
                               dif.mem_addr, dif.mem_wdata}, 64'd0);
         chk("reset_rdata", dif.resp_rdata, 64'd0);
      end else begin
         rdy = dif.req_ready;
         chk("ready_legal", ((rdy & ~dif.req_valid) != 0) || (rdy == 2'b11) ||
                            (rdy != 0 && dif.busy), 64'd0);
         if (rdy != 2'b00) begin
            id = int'(rdy[1]);
            if (dif.req_valid == 2'b11) chk("rr_fair", id, 1 - tb_last);
            if (last_acc >= 0) begin
               if (strict_gap) chk("accept_gap", cyc - last_acc, BEATS + 2);
               else            chk("accept_gap_min", (cyc - last_acc) >= BEATS + 2, 64'd1);
            end
            tb_last  = id;
            last_acc = cyc;
            acc_cnt[id]++;
            gseq.push_back(id);
            e.id    = id;
            e.wr    = dif.req_write[id];
            e.due   = cyc + BEATS + 1;
            e.rdata = '0;
            for (int b = 0; b < BEATS; b++) begin
               a = dif.req_addr[id] + 8'(b);
               if (e.wr) begin
                  w.addr = a;
                  w.data = dif.req_wdata[id][8*b +: 8];
                  w.old  = ref_mem[a];
                  ref_mem[a] = w.data;
                  wq.push_back(w);
               end else begin
                  e.rdata[8*b +: 8] = ref_mem[a];
               end
            end
            expq.push_back(e);
         end
         if (dif.mem_we) begin
            if (wq.size() == 0) begin
               chk("unexpected_write", 64'd1, 64'd0);
            end else begin
               w = wq.pop_front();
               chk("mem_addr", dif.mem_addr, w.addr);
               chk("mem_wdata", dif.mem_wdata, w.data);
            end
         end
         if (dif.resp_valid != 2'b00) begin
            if (expq.size() == 0) begin
               chk("unexpected_resp", dif.resp_valid, 64'd0);
            end else begin
               e  = expq.pop_front();
               oh = 2'b01 << e.id;
               chk("resp_id", dif.resp_valid, oh);
               chk("resp_time", cyc, e.due);
               if (!e.wr) held = e.rdata;
               chk("resp_rdata", dif.resp_rdata, held);
            end
         end else begin
            chk("rdata_held", dif.resp_rdata, held);
         end
      end
   end

   task automatic issue(input int id, input bit wr, input logic [7:0] a, input logic [31:0] d);
      int start;
      int n;
      start = acc_cnt[id];
      n = 0;
      rw[id] = wr;
      ra[id] = a;
      rd[id] = d;
      rv[id] = 1'b1;
      while (acc_cnt[id] == start && n < 50) begin
         @(posedge clock);
         n++;
      end
      if (n >= 50) chk("accept_timeout", 64'd0, 64'd1);
      #1;
      rv[id] = 1'b0;
      rw[id] = 1'($urandom);
      ra[id] = 8'($urandom);
      rd[id] = $urandom;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((expq.size() != 0 || dif.busy) && n < 100) begin
         @(posedge clock);
         #1;
         n++;
      end
      if (n >= 100) chk("idle_timeout", 64'd0, 64'd1);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] old22;
      logic [7:0] old23;
      int n;
      int pend_age [2];
      int seen [2];
      ra[0] = 8'h40; ra[1] = 8'h50;
      rd[0] = '0;    rd[1] = '0;
      rv = 2'b11;
      rw = 2'b00;
      repeat (3) @(posedge clock);
      #2 reset = 1'b0;
      strict_gap = 1'b1;
      #1 chk("post_reset_idle", dif.busy, 64'd0);
      n = 0;
      while (acc_cnt[0] + acc_cnt[1] < 4 && n < 100) begin
         @(posedge clock);
         n++;
      end
      #1 rv = 2'b00;
      strict_gap = 1'b0;
      chk("alt_count", gseq.size(), 64'd4);
      if (gseq.size() >= 4) chk("alt_order", {gseq[0][3:0], gseq[1][3:0], gseq[2][3:0], gseq[3][3:0]},
                                 64'h0101);
      wait_idle();

      issue(0, 1'b1, 8'h10, 32'hDEADBEEF);
      wait_idle();
      chk("t2_mem", {mem[8'h13], mem[8'h12], mem[8'h11], mem[8'h10]}, 64'hDEADBEEF);

      issue(1, 1'b0, 8'h10, 32'h0);
      wait_idle();
      repeat (2) @(posedge clock);
      #1 chk("t3_rdata_held", dif.resp_rdata, 64'hDEADBEEF);

      issue(0, 1'b1, 8'hFE, 32'h11223344);
      wait_idle();
      chk("t5_wrap_mem", {mem[8'h01], mem[8'h00], mem[8'hFF], mem[8'hFE]}, 64'h11223344);
      issue(1, 1'b0, 8'hFE, 32'h0);
      wait_idle();
      chk("t5_read", dif.resp_rdata, 64'h11223344);

      old22 = mem[8'h22];
      old23 = mem[8'h23];
      issue(0, 1'b1, 8'h20, 32'hA1B2C3D4);
      @(posedge clock);
      @(posedge clock);
      #2 reset = 1'b1;
      #1 chk("t6_we_drop", {dif.mem_we, dif.busy, dif.resp_valid}, 64'd0);
      repeat (2) @(posedge clock);
      #2 reset = 1'b0;
      chk("t6_partial_mem", {mem[8'h23], mem[8'h22], mem[8'h21], mem[8'h20]},
          {32'd0, old23, old22, 8'hC3, 8'hD4});
      issue(1, 1'b0, 8'h20, 32'h0);
      wait_idle();
      chk("t6_read_after", dif.resp_rdata, {32'd0, old23, old22, 8'hC3, 8'hD4});

      for (int i = 0; i < 2; i++) begin
         pend_age[i] = 0;
         seen[i]     = acc_cnt[i];
      end
      for (int c = 0; c < 1500; c++) begin
         @(posedge clock);
         #1;
         for (int i = 0; i < 2; i++) begin
            if (rv[i]) begin
               if (acc_cnt[i] != seen[i]) begin
                  chk("wait_bound", pend_age[i] <= WAIT_BOUND, 64'd1);
                  rv[i] = 1'b0;
                  rw[i] = 1'($urandom);
                  ra[i] = 8'($urandom);
                  rd[i] = $urandom;
               end else begin
                  pend_age[i]++;
               end
            end else if ($urandom_range(0, 2) == 0) begin
               seen[i]     = acc_cnt[i];
               pend_age[i] = 0;
               rw[i] = 1'($urandom);
               ra[i] = ($urandom_range(0, 3) == 0) ? 8'hFC + 8'($urandom_range(0, 3)) : 8'($urandom);
               rd[i] = $urandom;
               rv[i] = 1'b1;
            end
         end
      end
      for (int i = 0; i < 2; i++) begin
         if (rv[i]) chk("pending_bound", pend_age[i] <= WAIT_BOUND, 64'd1);
      end
      rv = 2'b00;
      @(posedge clock);
      #1;
      wait_idle();
      chk("queues_drained", expq.size() + wq.size(), 64'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
